// File: rtl/id_exe_stage.sv
// rtl/id_exe_stage.sv - ID/EXE pipeline register with load-use stall, WB bypass and halt drain
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   valid_ID, halt_ID        ID instruction valid / is a halt
//   rs_IF_ID, rt_IF_ID       ID source register numbers
//   num_write_ID, ctrl_ID    ID destination and packed controls
//   reg_a_ID, reg_b_ID       register-file read data
//   imm_ID                   extended immediate
//   FA1, FB1                 0 = take wb_data_MEM_WB, 1 = take register-file data
//   wb_data_MEM_WB           value being written back this cycle
//   flush                    kill the ID instruction
//   *_ID_EXE                 registered ID/EXE fields
//   stall                    combinational freeze of PC and IF/ID
//   halted                   processor halted
module id_exe_stage #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_ID,
    input  logic [4:0]  rs_IF_ID,
    input  logic [4:0]  rt_IF_ID,
    input  logic [4:0]  num_write_ID,
    input  logic [7:0]  ctrl_ID,
    input  logic        halt_ID,
    input  logic [31:0] reg_a_ID,
    input  logic [31:0] reg_b_ID,
    input  logic [31:0] imm_ID,
    input  logic        FA1,
    input  logic        FB1,
    input  logic [31:0] wb_data_MEM_WB,
    input  logic        flush,
    output logic [4:0]  rs_ID_EXE,
    output logic [4:0]  rt_ID_EXE,
    output logic [4:0]  num_write_ID_EXE,
    output logic [7:0]  ctrl_ID_EXE,
    output logic [31:0] a_ID_EXE,
    output logic [31:0] b_ID_EXE,
    output logic [31:0] imm_ID_EXE,
    output logic        valid_ID_EXE,
    output logic        stall,
    output logic        halted
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Counter only has to hold DRAIN_CYCLES-1.
    localparam int            CW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic [4:0]    r_num_write;
    logic [7:0]    r_ctrl;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_imm;
    logic          r_valid;
    logic          r_halted;

    logic          w_luse;
    logic          w_stall;
    logic          w_capture;
    logic          w_halt_take;
    logic [31:0]   w_a;
    logic [31:0]   w_b;

    // Register 0 never carries a dependency, so a load targeting it cannot stall.
    assign w_luse = r_valid & r_ctrl[1] & (r_rt != 5'd0) & valid_ID &
                    ((r_rt == rs_IF_ID) | (r_rt == rt_IF_ID));

    // Flush overrides everything: the ID instruction dies anyway, so there is nothing to hold.
    assign w_stall     = ~flush & (w_luse | (r_state != ST_RUN));
    assign w_capture   = ~flush & ~w_stall & valid_ID;
    assign w_halt_take = w_capture & halt_ID & (r_state == ST_RUN);

    assign w_a = FA1 ? reg_a_ID : wb_data_MEM_WB;
    assign w_b = FB1 ? reg_b_ID : wb_data_MEM_WB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_num_write <= '0;
            r_ctrl      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_valid     <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_rs        <= rs_IF_ID;
                r_rt        <= rt_IF_ID;
                r_num_write <= num_write_ID;
                // A halt travels down the pipe as a valid no-op.
                r_ctrl      <= halt_ID ? 8'd0 : ctrl_ID;
                r_a         <= w_a;
                r_b         <= w_b;
                r_imm       <= imm_ID;
                r_valid     <= 1'b1;
            end else begin
                r_rs        <= '0;
                r_rt        <= '0;
                r_num_write <= '0;
                r_ctrl      <= '0;
                r_a         <= '0;
                r_b         <= '0;
                r_imm       <= '0;
                r_valid     <= 1'b0;
            end

            case (r_state)
                ST_RUN: begin
                    if (w_halt_take) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= CNT_INIT;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign rs_ID_EXE        = r_rs;
    assign rt_ID_EXE        = r_rt;
    assign num_write_ID_EXE = r_num_write;
    assign ctrl_ID_EXE      = r_ctrl;
    assign a_ID_EXE         = r_a;
    assign b_ID_EXE         = r_b;
    assign imm_ID_EXE       = r_imm;
    assign valid_ID_EXE     = r_valid;
    assign stall            = w_stall;
    assign halted           = r_halted;

endmodule

// File: doc/id_exe_stage.md
ID_EXE_STAGE -- requirements
Module: id_exe_stage

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3, cycles from halt capture to halted assertion (EXE, MEM, WB).
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid_ID  input  1  instruction in IF/ID is valid.
REQ-005 rs_IF_ID, rt_IF_ID  input  5 each  source register numbers in ID.
REQ-006 num_write_ID  input  5  destination register number already selected in ID.
REQ-007 ctrl_ID  input  8  packed controls: [0]reg_write [1]mem_read [2]mem_write [3]alu_src [7:4]alu_op.
REQ-008 halt_ID  input  1  ID instruction is halt.
REQ-009 reg_a_ID, reg_b_ID, imm_ID  input  32 each  register-file read data and extended immediate.
REQ-010 FA1, FB1  input  1 each  WB-to-ID bypass selects; 0 = use wb_data_MEM_WB, 1 = use register-file data.
REQ-011 wb_data_MEM_WB  input  32  value being written back this cycle.
REQ-012 flush  input  1  branch/jump resolved taken in EXE; kill ID instruction.
REQ-013 rs_ID_EXE, rt_ID_EXE, num_write_ID_EXE  output  5 each  registered register numbers for the forwarding unit.
REQ-014 ctrl_ID_EXE  output  8  registered controls, same bit map as ctrl_ID.
REQ-015 a_ID_EXE, b_ID_EXE, imm_ID_EXE  output  32 each  registered operands.
REQ-016 valid_ID_EXE  output  1  registered valid.
REQ-017 stall  output  1  combinational; freezes PC and IF/ID.
REQ-018 halted  output  1  registered; processor halted.

Function
REQ-019 Capture path: a = FA1 ? reg_a_ID : wb_data_MEM_WB; b = FB1 ? reg_b_ID : wb_data_MEM_WB; SHALL be latched with all ID fields on the next edge (latency 1).
REQ-020 Load-use hazard: luse = valid_ID_EXE & ctrl_ID_EXE[1] & rt_ID_EXE!=0 & valid_ID & (rt_ID_EXE==rs_IF_ID | rt_ID_EXE==rt_IF_ID).
REQ-021 stall SHALL = !flush & (luse | state!=RUN).
REQ-022 Bubble: valid, ctrl, rs, rt, num_write all 0; operands don't-care but SHALL be 0.
REQ-023 Edge priority: flush -> bubble; else stall -> bubble; else valid_ID=0 -> bubble; else capture.
REQ-024 Halt capture: in RUN with valid_ID & halt_ID & !stall & !flush, latch instruction with ctrl forced to 0, valid=1; state -> DRAIN, counter = DRAIN_CYCLES-1.
REQ-025 States RUN, DRAIN, HALTED; DRAIN decrements each edge, -> HALTED when counter 0; HALTED held until reset.
REQ-026 halted SHALL be 1 exactly in HALTED, asserting DRAIN_CYCLES edges after the halt-capture edge.
REQ-027 halt_ID with flush in same cycle SHALL be discarded; state stays RUN.
REQ-028 halt_ID during luse SHALL wait; captured on the first non-stalled edge.
REQ-029 During DRAIN/HALTED every edge SHALL insert a bubble; flush in these states SHALL be ignored by the state machine.
REQ-030 rs/rt numbers 0 SHALL never raise luse; register 0 is not a hazard source.

Reset
REQ-031 rst_n low SHALL immediately force all registered outputs to 0, state RUN, counter 0; stall SHALL read 0 during and after reset.
REQ-032 Reset asserted mid-DRAIN or in HALTED SHALL return to RUN; first capture on the first edge after rst_n rises.

Verification
REQ-033 Capture: valid_ID=1, rs=3, rt=4, num_write=5, ctrl=8'h21, reg_a=32'h11, FA1=1 -> next edge outputs rs=3, rt=4, num_write=5, ctrl=8'h21, a=32'h11, valid=1.
REQ-034 Bypass: FA1=0, FB1=0, wb_data=32'hDEAD_BEEF -> a_ID_EXE=b_ID_EXE=32'hDEAD_BEEF.
REQ-035 Load-use: EXE holds load rt=8 (ctrl[1]=1); ID rs=8 -> stall=1 one cycle, next edge bubble, following edge ID instruction captured, stall=0.
REQ-036 Halt: halt_ID accepted at edge N -> stall=1 from N, bubbles at N+1..N+3, halted=1 after edge N+3, holds indefinitely.
REQ-037 Flush vs halt: halt_ID with flush=1 -> bubble, state RUN, halted stays 0; rst_n pulse in HALTED -> all outputs 0, halted=0.
